// File: rtl/cpu_mem_unit_pkg.sv
// Shared definitions for the CPU memory unit.
// Holds the CPU mode encodings driven on cpustate, the internal FSM state type,
// and the data / CPU address widths used by the top level and the storage array.
package cpu_mem_unit_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CPU_AW = 16;

    // cpustate encodings; 2'b11 is not listed and behaves like ST_IDLE
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_LOAD  = 2'b10,
        S_CLEAR = 2'b11
    } state_e;

endpackage

// File: rtl/cpu_mem_unit_mem_array.sv
// Byte storage for the CPU memory unit: 2**AW x DW entries, one synchronous
// write port and one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk_i    write clock
//   we_i     write enable, sampled on posedge clk_i
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
module cpu_mem_unit_mem_array #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_mem_unit.sv
// CPU program/data memory unit. Sits downstream of the CPU bus interface and owns
// the only memory array. In RUN mode the CPU reads (zero latency) and writes the
// array; in LOAD mode a byte-serial loader fills it from LOAD_BASE upwards; a clear
// request sweeps every location to zero.
// Optional feature: define MEM_LOAD_CHECKSUM_EN to add ld_sum, the modulo-256 sum of
// bytes accepted since the last entry into LOAD mode.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   cpustate   mode request: 00 IDLE, 01 RUN, 10 LOAD, 11 IDLE
//   cpu_addr   CPU address; bits above AW must be zero for an in-range access
//   cpu_wdata  CPU write data
//   cpu_read   CPU read strobe
//   cpu_write  CPU write strobe
//   cpu_rdata  read data (zero unless a valid in-range RUN read)
//   ld_data    loader byte
//   ld_valid   loader byte valid
//   ld_ready   loader may transfer (high only in LOAD)
//   ld_addr    next address the loader will write
//   clr_req    request a full-memory clear (taken from IDLE only)
//   busy       clear sweep in progress
//   ld_sum     loader checksum (only with MEM_LOAD_CHECKSUM_EN)
//   addr_err   sticky flag: CPU access with cpu_addr >= DEPTH
module cpu_mem_unit
    import cpu_mem_unit_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [AW-1:0]     ld_addr,
    input  logic              clr_req,
    output logic              busy,
`ifdef MEM_LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] ld_sum,
`endif
    output logic              addr_err
);

    localparam int unsigned   DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] BASE_ADDR = AW'(LOAD_BASE);

    state_e          state_q, state_d;
    logic            ld_ready_q, ld_ready_d;
    logic            busy_q, busy_d;
    logic            addr_err_q, addr_err_d;
    logic [AW-1:0]   ld_addr_q, ld_addr_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

    logic              in_range;
    logic              enter_load;
    logic              ld_accept;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Any address bit at or above AW makes the access out of range.
    assign in_range   = (cpu_addr >> AW) == '0;
    assign enter_load = (state_q == S_IDLE) && !clr_req && (cpustate == ST_LOAD);
    assign ld_accept  = (state_q == S_LOAD) && ld_valid && ld_ready_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ld_ready_d = ld_ready_q;
        busy_d     = busy_q;
        addr_err_d = addr_err_q;
        ld_addr_d  = ld_addr_q;
        clr_cnt_d  = clr_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d    = S_CLEAR;
                    clr_cnt_d  = '0;
                    busy_d     = 1'b1;
                    addr_err_d = 1'b0;
                end else if (cpustate == ST_RUN) begin
                    state_d = S_RUN;
                end else if (cpustate == ST_LOAD) begin
                    state_d    = S_LOAD;
                    ld_addr_d  = BASE_ADDR;
                    ld_ready_d = 1'b1;
                    addr_err_d = 1'b0;
                end
            end

            S_RUN: begin
                if ((cpu_read || cpu_write) && !in_range) begin
                    addr_err_d = 1'b1;
                end
                if (cpustate != ST_RUN) begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD: begin
                // Natural AW-bit overflow gives the DEPTH-1 -> 0 wrap.
                if (ld_accept) begin
                    ld_addr_d = ld_addr_q + AW'(1);
                end
                if (cpustate != ST_LOAD) begin
                    state_d    = S_IDLE;
                    ld_ready_d = 1'b0;
                end
            end

            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
            ld_addr_q  <= '0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            addr_err_q <= addr_err_d;
            ld_addr_q  <= ld_addr_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Single write port shared by CPU, loader and clear sweep
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr[AW-1:0];
        mem_wdata = cpu_wdata;
        case (state_q)
            S_RUN: begin
                mem_we = cpu_write && in_range;
            end
            S_LOAD: begin
                mem_we    = ld_accept;
                mem_waddr = ld_addr_q;
                mem_wdata = ld_data;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    cpu_mem_unit_mem_array #(
        .AW (AW),
        .DW (DATA_W)
    ) u_mem_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (cpu_addr[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Read data reflects pre-edge contents, so a same-cycle write shows up next cycle.
    assign cpu_rdata = ((state_q == S_RUN) && cpu_read && in_range) ? mem_rdata : '0;
    assign ld_ready  = ld_ready_q;
    assign ld_addr   = ld_addr_q;
    assign busy      = busy_q;
    assign addr_err  = addr_err_q;

`ifdef MEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] ld_sum_q, ld_sum_d;

    always_comb begin
        ld_sum_d = ld_sum_q;
        if (enter_load) begin
            ld_sum_d = '0;
        end else if (ld_accept) begin
            ld_sum_d = ld_sum_q + ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_sum_q <= '0;
        end else begin
            ld_sum_q <= ld_sum_d;
        end
    end

    assign ld_sum = ld_sum_q;
`else
    // enter_load only feeds the checksum.
    logic unused_enter_load;
    assign unused_enter_load = enter_load;
`endif

endmodule

// File: tb/tb_cpu_mem_unit.sv
// Self-checking bench for cpu_mem_unit. A behavioural model (byte array, loader
// pointer, sticky error flag, checksum) predicts every compared value. A second
// instance with LOAD_BASE = 8'hFE exercises loader address wrap.
module tb_cpu_mem_unit;
    import cpu_mem_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpustate;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic        clr_req;
    logic        busy;
    logic        addr_err;

    logic [1:0]  w_cpustate;
    logic [15:0] w_cpu_addr;
    logic        w_cpu_read;
    logic [7:0]  w_cpu_rdata;
    logic [7:0]  w_ld_data;
    logic        w_ld_valid;
    logic        w_ld_ready;
    logic [7:0]  w_ld_addr;
    logic        w_busy;
    logic        w_addr_err;
`ifdef MEM_LOAD_CHECKSUM_EN
    logic [7:0]  ld_sum;
    logic [7:0]  w_ld_sum;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_mem [256];
    logic [7:0] w_mem [256];
    int         m_ld_addr;
    logic       m_err;
    int         m_sum;

    always #5 clk = ~clk;

    cpu_mem_unit #(.AW(8), .LOAD_BASE(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpustate  (cpustate),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .clr_req   (clr_req),
        .busy      (busy),
`ifdef MEM_LOAD_CHECKSUM_EN
        .ld_sum    (ld_sum),
`endif
        .addr_err  (addr_err)
    );

    cpu_mem_unit #(.AW(8), .LOAD_BASE(8'hFE)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .cpustate  (w_cpustate),
        .cpu_addr  (w_cpu_addr),
        .cpu_wdata (8'h00),
        .cpu_read  (w_cpu_read),
        .cpu_write (1'b0),
        .cpu_rdata (w_cpu_rdata),
        .ld_data   (w_ld_data),
        .ld_valid  (w_ld_valid),
        .ld_ready  (w_ld_ready),
        .ld_addr   (w_ld_addr),
        .clr_req   (1'b0),
        .busy      (w_busy),
`ifdef MEM_LOAD_CHECKSUM_EN
        .ld_sum    (w_ld_sum),
`endif
        .addr_err  (w_addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        ld_valid  = 1'b0;
        clr_req   = 1'b0;
    endtask

    // Walk through IDLE into the requested mode and update the model accordingly.
    task automatic set_mode(input logic [1:0] m);
        idle_strobes();
        cpustate = ST_IDLE;
        tick();
        tick();
        cpustate = m;
        tick();
        if (m == ST_LOAD) begin
            m_ld_addr = 0;
            m_err     = 1'b0;
            m_sum     = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cpustate = ST_RUN; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        cpu_read = 1'b1; cpu_write = 1'b0; ld_data = 8'h00; ld_valid = 1'b0; clr_req = 1'b0;
        w_cpustate = ST_IDLE; w_cpu_addr = 16'h0000; w_cpu_read = 1'b0;
        w_ld_data = 8'h00; w_ld_valid = 1'b0;
        m_ld_addr = 0; m_err = 1'b0; m_sum = 0;
        #3;
        repeat (2) @(posedge clk);
        #2;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        n_vec++; if (ld_addr !== 8'h00) begin n_err++; $display("FAIL reset_ld_addr: got %h want 00", ld_addr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
`ifdef MEM_LOAD_CHECKSUM_EN
        n_vec++; if (ld_sum !== 8'h00) begin n_err++; $display("FAIL reset_ld_sum: got %h want 00", ld_sum); end
`endif
        cpustate = ST_IDLE;
        cpu_read = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_clear();
        int cnt;
        logic ready_seen;
        cpustate = ST_IDLE; idle_strobes();
        tick();
        clr_req = 1'b1;
        tick();
        // Everything below should be ignored while the sweep runs.
        clr_req = 1'b0; cpustate = ST_RUN;
        ld_valid = 1'b1; ld_data = 8'hEE;
        cnt = 0; ready_seen = 1'b0;
        while (busy === 1'b1 && cnt < 300) begin
            if (ld_ready !== 1'b0) ready_seen = 1'b1;
            cnt++;
            tick();
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        n_vec++; if (cnt != 256) begin n_err++; $display("FAIL clear_busy_cycles: got %0d want 256", cnt); end
        n_vec++; if (ready_seen) begin n_err++; $display("FAIL clear_ld_ready: got 1 want 0"); end
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL clear_addr_err: got %b want 0", addr_err); end
        tick();
        cpu_read = 1'b1;
        for (int a = 0; a < 256; a++) begin
            cpu_addr = 16'(a);
            #1;
            n_vec++;
            if (cpu_rdata !== 8'h00) begin
                n_err++; $display("FAIL clear_mem[%0d]: got %h want 00", a, cpu_rdata);
            end
        end
        cpu_read = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] b;
        logic       v;
        set_mode(ST_LOAD);
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b want 1", ld_ready); end
        n_vec++; if (ld_addr !== 8'h00) begin n_err++; $display("FAIL load_base: got %h want 00", ld_addr); end
        for (int i = 0; i < 23; i++) begin
            if (i < 3) begin
                b = 8'(8'h11 * (i + 1)); v = 1'b1;
            end else begin
                b = 8'($urandom); v = 1'($urandom_range(0, 1));
            end
            ld_data = b; ld_valid = v;
            tick();
            if (v) begin
                m_mem[m_ld_addr] = b;
                m_ld_addr = (m_ld_addr + 1) % 256;
                m_sum = (m_sum + int'(b)) % 256;
            end
            n_vec++;
            if (ld_addr !== 8'(m_ld_addr)) begin
                n_err++; $display("FAIL load_addr step %0d: got %h want %h", i, ld_addr, 8'(m_ld_addr));
            end
            if (i == 2) begin
                n_vec++; if (ld_addr !== 8'h03) begin n_err++; $display("FAIL load_addr_3: got %h want 03", ld_addr); end
            end
        end
        ld_valid = 1'b0;
        cpustate = ST_RUN;
        tick();
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL load_exit_ready: got %b want 0", ld_ready); end
        n_vec++; if (ld_addr !== 8'(m_ld_addr)) begin n_err++; $display("FAIL load_exit_addr: got %h want %h", ld_addr, 8'(m_ld_addr)); end
        tick();
        cpu_read = 1'b1; cpu_addr = 16'h0001;
        #1;
        n_vec++; if (cpu_rdata !== 8'h22) begin n_err++; $display("FAIL load_read_1: got %h want 22", cpu_rdata); end
        for (int a = 0; a < m_ld_addr; a++) begin
            cpu_addr = 16'(a);
            #1;
            n_vec++;
            if (cpu_rdata !== m_mem[a]) begin
                n_err++; $display("FAIL load_mem[%0d]: got %h want %h", a, cpu_rdata, m_mem[a]);
            end
        end
        cpu_read = 1'b0;
`ifdef MEM_LOAD_CHECKSUM_EN
        n_vec++; if (ld_sum !== 8'(m_sum)) begin n_err++; $display("FAIL load_sum: got %h want %h", ld_sum, 8'(m_sum)); end
`endif
    endtask

    task automatic test_run_write();
        cpu_write = 1'b1; cpu_read = 1'b0; cpu_addr = 16'h0005; cpu_wdata = 8'hA5;
        tick();
        m_mem[5] = 8'hA5;
        cpu_write = 1'b0; cpu_read = 1'b1;
        #1;
        n_vec++; if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL run_read_5: got %h want a5", cpu_rdata); end
        cpu_write = 1'b1; cpu_wdata = 8'h5A;
        #1;
        n_vec++; if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL run_rw_same_cycle: got %h want a5", cpu_rdata); end
        tick();
        m_mem[5] = 8'h5A;
        cpu_write = 1'b0;
        #1;
        n_vec++; if (cpu_rdata !== 8'h5A) begin n_err++; $display("FAIL run_rw_next_cycle: got %h want 5a", cpu_rdata); end
        cpu_read = 1'b0;
        #1;
        n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL run_no_read: got %h want 00", cpu_rdata); end
    endtask

    task automatic test_out_of_range();
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_pre: got %b want 0", addr_err); end
        cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hFF;
        #1;
        n_vec++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL oor_rdata: got %h want 00", cpu_rdata); end
        tick();
        m_err = 1'b1;
        cpu_write = 1'b0; cpu_addr = 16'h0000;
        #1;
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_err_set: got %b want 1", addr_err); end
        n_vec++; if (cpu_rdata !== m_mem[0]) begin n_err++; $display("FAIL oor_mem0: got %h want %h", cpu_rdata, m_mem[0]); end
        repeat (3) tick();
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_sticky: got %b want 1", addr_err); end
        set_mode(ST_LOAD);
        n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_load_clears: got %b want 0", addr_err); end
        set_mode(ST_RUN);
    endtask

    task automatic test_random_run();
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rd, wr, inr;
        logic [7:0]  exp_rd;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
            else a = {8'h00, 8'($urandom)};
            wd = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            inr = (a < 16'd256);
            cpu_addr = a; cpu_wdata = wd; cpu_read = rd; cpu_write = wr;
            exp_rd = (rd && inr) ? m_mem[a[7:0]] : 8'h00;
            #1;
            n_vec++;
            if (cpu_rdata !== exp_rd) begin
                n_err++; $display("FAIL rand_rdata %0d addr %h: got %h want %h", i, a, cpu_rdata, exp_rd);
            end
            tick();
            if (wr && inr) m_mem[a[7:0]] = wd;
            if ((rd || wr) && !inr) m_err = 1'b1;
            n_vec++;
            if (addr_err !== m_err) begin
                n_err++; $display("FAIL rand_addr_err %0d: got %b want %b", i, addr_err, m_err);
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 0; a < 11; a++) begin
            cpu_write = 1'b1; cpu_addr = 16'(a); cpu_wdata = 8'($urandom_range(1, 255));
            tick();
            m_mem[a] = cpu_wdata;
        end
        cpu_addr = 16'd200; cpu_wdata = 8'($urandom_range(1, 255));
        tick();
        m_mem[200] = cpu_wdata;
        cpu_write = 1'b0;
        cpustate = ST_IDLE;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        for (int a = 0; a < 10; a++) m_mem[a] = 8'h00;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midclr_busy_after: got %b want 0", busy); end
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL midclr_ld_ready: got %b want 0", ld_ready); end
        @(negedge clk);
        rst = 1'b1;
        cpustate = ST_RUN;
        tick();
        cpu_read = 1'b1;
        for (int a = 0; a < 12; a++) begin
            cpu_addr = (a == 11) ? 16'd200 : 16'(a);
            #1;
            n_vec++;
            if (cpu_rdata !== m_mem[cpu_addr[7:0]]) begin
                n_err++; $display("FAIL midclr_mem[%0d]: got %h want %h", cpu_addr, cpu_rdata, m_mem[cpu_addr[7:0]]);
            end
        end
        cpu_read = 1'b0;
    endtask

    task automatic test_wrap();
        int wa;
        logic [7:0] b;
        w_cpustate = ST_LOAD;
        tick();
        wa = 254;
        n_vec++; if (w_ld_addr !== 8'hFE) begin n_err++; $display("FAIL wrap_base: got %h want fe", w_ld_addr); end
        n_vec++; if (w_ld_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready: got %b want 1", w_ld_ready); end
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            w_ld_data = b; w_ld_valid = 1'b1;
            tick();
            w_mem[wa] = b;
            wa = (wa + 1) % 256;
        end
        w_ld_valid = 1'b0;
        n_vec++; if (w_ld_addr !== 8'h01) begin n_err++; $display("FAIL wrap_addr: got %h want 01", w_ld_addr); end
        w_cpustate = ST_RUN;
        tick();
        tick();
        w_cpu_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wa = (254 + i) % 256;
            w_cpu_addr = 16'(wa);
            #1;
            n_vec++;
            if (w_cpu_rdata !== w_mem[wa]) begin
                n_err++; $display("FAIL wrap_mem[%0d]: got %h want %h", wa, w_cpu_rdata, w_mem[wa]);
            end
        end
        w_cpu_read = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_run_write();
        test_out_of_range();
        test_random_run();
        test_reset_mid_clear();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_mem_unit.md
Name: cpu_mem_unit

Overview:
- Byte-wide program/data memory that sits directly downstream of the CPU bus interface.
- Consumes the CPU's address, write data and read/write strobes, and returns read data.
- Also provides a switch/serial loader port for entering programs while the CPU is stopped, plus a hardware clear sweep.
- Owns the only memory array in the design.

Parameters:
AW, 8, implemented address bits; DEPTH = 2**AW bytes
LOAD_BASE, 0, first address written after entering LOAD mode

Ports:
clk  input  1  system clock; same clock the CPU registers use
rst  input  1  asynchronous active-low reset
cpustate  input  2  mode: 2'b00 IDLE, 2'b01 RUN, 2'b10 LOAD, 2'b11 treated as IDLE
cpu_addr  input  16  CPU address bus
cpu_wdata  input  8  CPU write data
cpu_read  input  1  CPU read strobe
cpu_write  input  1  CPU write strobe
cpu_rdata  output  8  read data to CPU data input
ld_data  input  8  loader byte
ld_valid  input  1  loader byte valid
ld_ready  output  1  loader may transfer
ld_addr  output  AW  next loader write address
clr_req  input  1  request full-memory clear (level or pulse)
busy  output  1  clear sweep in progress
addr_err  output  1  sticky: CPU access with cpu_addr >= DEPTH

Behaviour:
- Array: DEPTH x 8, asynchronous (combinational) read, write on posedge clk. Contents are not reset.
- Reset (rst=0, async): state IDLE; ld_ready=0, ld_addr=0, busy=0, addr_err=0, cpu_rdata=8'h00, clear counter=0.
- FSM states: S_IDLE, S_RUN, S_LOAD, S_CLEAR.
- S_IDLE transitions, in priority order:
  - clr_req=1 -> S_CLEAR, counter=0.
  - else cpustate=RUN -> S_RUN.
  - else cpustate=LOAD -> S_LOAD, ld_addr=LOAD_BASE.
- S_RUN:
  - cpu_rdata = mem[cpu_addr[AW-1:0]] when cpu_read=1 and the address is in range; otherwise 8'h00. Zero latency.
  - cpu_write=1 with the address in range -> mem written at that edge.
  - Out-of-range access (cpu_addr[15:AW]!=0): the write is dropped, cpu_rdata=8'h00, and addr_err is set next edge.
  - cpu_read and cpu_write together: the write commits; cpu_rdata shows the pre-edge contents.
  - cpustate!=RUN -> S_IDLE next edge.
  - clr_req is ignored in this state.
- S_LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready: mem[ld_addr]=ld_data, ld_addr+1.
  - ld_addr wraps from DEPTH-1 to 0.
  - Entering S_LOAD clears addr_err.
  - cpustate!=LOAD -> S_IDLE next edge. ld_ready drops that same edge; ld_addr holds its value.
  - CPU strobes are ignored; cpu_rdata=8'h00.
- S_CLEAR:
  - busy=1.
  - Each cycle writes mem[counter]=8'h00, then counter+1.
  - After writing DEPTH-1 -> S_IDLE; busy=0 on the next edge. Total DEPTH cycles.
  - cpustate, clr_req, CPU strobes and the loader are ignored; ld_ready=0.
  - addr_err is cleared on entry.
- Outside S_RUN/S_LOAD, cpu_rdata=8'h00 and ld_ready=0.
- Reset mid-clear or mid-load: immediate abort to S_IDLE. Memory keeps whatever was already written.

Optional Feature:
- Macro MEM_LOAD_CHECKSUM_EN.
- Defined: adds output ld_sum[7:0].
  - Reset to 0 and cleared on entry to S_LOAD.
  - Each accepted loader byte adds ld_data modulo 256.
  - Holds its value outside S_LOAD.
- Undefined: no port, no adder; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - cpustate encodings: ST_IDLE=2'b00, ST_RUN=2'b01, ST_LOAD=2'b10.
  - FSM state typedef.
  - Data width constant (8) and CPU address width (16).
- One natural sub-module, mem_array: DEPTH x 8 storage, async read, single write port.
  - The top level muxes that port between CPU, loader and clear sweep.

Test Plan:
- Load: after reset, cpustate=LOAD, send bytes 8'h11,8'h22,8'h33 with ld_valid -> mem[0..2]=11,22,33, ld_addr=3. Then cpustate=RUN, cpu_read at addr 16'h0001 -> cpu_rdata=8'h22 in the same cycle.
- Run write: cpu_write addr 16'h0005, data 8'hA5, then cpu_read 16'h0005 -> 8'hA5. Simultaneous read+write at addr 5 with data 8'h5A -> cpu_rdata=8'hA5 that cycle, 8'h5A the next.
- Out of range: cpu_write addr 16'h0100 (AW=8), data 8'hFF -> mem[0] unchanged, cpu_rdata=8'h00, addr_err=1. Re-entering LOAD -> addr_err=0.
- Wrap: AW=8, LOAD_BASE=8'hFE, load 3 bytes -> written to FE, FF, 00; ld_addr=8'h01.
- Clear: clr_req in IDLE -> busy=1 for exactly 256 cycles, all locations read 8'h00 in RUN. A cpustate change during the sweep has no effect until busy=0.
- Reset mid-clear: assert rst at sweep count 10 -> busy=0 and state IDLE immediately. Locations 0..9 read 0; location 200 retains its prior value.
